// File: rtl/clk_en_gen_pkg.sv
// Shared types and helpers for the clock-enable generator.
// Holds FSM states, default sizes and field-slicing helpers.
package clk_en_gen_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_STABLE = 2'd1,
        ALIGN       = 2'd2,
        RUN         = 2'd3
    } state_e;

    localparam int DEF_CH          = 4;
    localparam int DEF_DIV_W       = 8;
    localparam int DEF_LOCK_CYCLES = 1024;

    // Bits needed to count 0 .. cycles-1.
    function automatic int stab_w(input int cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

    // Low bit of channel idx in a packed per-channel bus.
    function automatic int fld_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/clk_en_chan.sv
// One enable channel: period counter, divide shadow, phase load.
// Ports: clk, rst, load_i (ALIGN), tick_i (stay in RUN), div_i,
// phase_i, frac_i (only with CLKEN_FRAC_EN), ce_o.
module clk_en_chan
    import clk_en_gen_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
`ifdef CLKEN_FRAC_EN
    , parameter int FRAC_W = 8
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              tick_i,
    input  logic [DIV_W-1:0]  div_i,
    input  logic [DIV_W-1:0]  phase_i,
`ifdef CLKEN_FRAC_EN
    input  logic [FRAC_W-1:0] frac_i,
`endif
    output logic              ce_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             ce_q, ce_d;
    logic [DIV_W:0]   last;
    logic             wrap;
    logic [DIV_W-1:0] load_cnt;

`ifdef CLKEN_FRAC_EN
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              ext_q, ext_d;
    logic [FRAC_W:0]   acc_sum;

    assign acc_sum = {1'b0, acc_q} + {1'b0, frac_i};
    // A carry stretches the following period by one cycle.
    assign last = {1'b0, div_q} - (DIV_W+1)'(1)
                + (DIV_W+1)'(ext_q);
`else
    // One extra bit keeps div_q=0 from underflowing.
    assign last = {1'b0, div_q} - (DIV_W+1)'(1);
`endif

    assign wrap = (div_q != '0) && ({1'b0, cnt_q} == last);

    // Phase beyond the period is clamped to the last count.
    always_comb begin
        load_cnt = phase_i;
        if (div_i == '0)
            load_cnt = '0;
        else if (phase_i >= div_i)
            load_cnt = div_i - DIV_W'(1);
    end

    always_comb begin
        cnt_d = cnt_q;
        div_d = div_q;
        ce_d  = 1'b0;
`ifdef CLKEN_FRAC_EN
        acc_d = acc_q;
        ext_d = ext_q;
`endif
        if (load_i) begin
            cnt_d = load_cnt;
            div_d = div_i;
`ifdef CLKEN_FRAC_EN
            acc_d = '0;
            ext_d = 1'b0;
`endif
        end else if (tick_i && wrap) begin
            ce_d  = 1'b1;
            cnt_d = '0;
            div_d = div_i;
`ifdef CLKEN_FRAC_EN
            acc_d = acc_sum[FRAC_W-1:0];
            ext_d = acc_sum[FRAC_W];
`endif
        end else if (tick_i && div_q != '0) begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            div_q <= '0;
            ce_q  <= 1'b0;
`ifdef CLKEN_FRAC_EN
            acc_q <= '0;
            ext_q <= 1'b0;
`endif
        end else begin
            cnt_q <= cnt_d;
            div_q <= div_d;
            ce_q  <= ce_d;
`ifdef CLKEN_FRAC_EN
            acc_q <= acc_d;
            ext_q <= ext_d;
`endif
        end
    end

    assign ce_o = ce_q;

endmodule

// File: rtl/clk_en_gen.sv
// Multi-channel clock-enable generator behind the PLL wrapper.
// Ports: clk, rst, pll_locked, resync, div, phase, frac (only with
// CLKEN_FRAC_EN), ce, ready, lock_lost, state.
module clk_en_gen
    import clk_en_gen_pkg::*;
#(
    parameter int CH          = DEF_CH,
    parameter int DIV_W       = DEF_DIV_W,
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
`ifdef CLKEN_FRAC_EN
    , parameter int FRAC_W = 8
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pll_locked,
    input  logic                resync,
    input  logic [CH*DIV_W-1:0] div,
    input  logic [CH*DIV_W-1:0] phase,
`ifdef CLKEN_FRAC_EN
    input  logic [CH*FRAC_W-1:0] frac,
`endif
    output logic [CH-1:0]       ce,
    output logic                ready,
    output logic                lock_lost,
    output logic [1:0]          state
);

    localparam int SW = stab_w(LOCK_CYCLES);
    localparam logic [SW-1:0] STAB_LAST = SW'(LOCK_CYCLES - 1);

    state_e        state_q, state_d;
    logic          sync1_q, sync2_q;
    logic          lk;
    logic [SW-1:0] stab_q, stab_d;
    logic          ready_q;
    logic          lost_q, lost_d;
    logic          tick;
    logic          load;

    assign lk = sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            stab_q  <= '0;
            ready_q <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= pll_locked;
            sync2_q <= sync1_q;
            stab_q  <= stab_d;
            ready_q <= (state_d == RUN);
            lost_q  <= lost_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (lk)
                    state_d = WAIT_STABLE;
            end
            WAIT_STABLE: begin
                if (!lk)
                    state_d = IDLE;
                else if (stab_q == STAB_LAST)
                    state_d = ALIGN;
            end
            ALIGN: begin
                state_d = lk ? RUN : IDLE;
            end
            RUN: begin
                if (!lk)
                    state_d = IDLE;
                else if (resync)
                    state_d = ALIGN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stab_d = '0;
        if (state_q == WAIT_STABLE && state_d == WAIT_STABLE)
            stab_d = stab_q + SW'(1);
        // Loss of lock outranks a simultaneous resync.
        lost_d = lost_q;
        if (state_q == RUN && !lk)
            lost_d = 1'b1;
        else if (resync)
            lost_d = 1'b0;
        // Channels only advance while RUN is held, so leaving
        // RUN drops every enable on the next cycle.
        tick = (state_q == RUN) && (state_d == RUN);
        load = (state_q == ALIGN);
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        localparam int DLO = fld_lo(g, DIV_W);
`ifdef CLKEN_FRAC_EN
        localparam int FLO = fld_lo(g, FRAC_W);
`endif
        clk_en_chan #(
            .DIV_W(DIV_W)
`ifdef CLKEN_FRAC_EN
            , .FRAC_W(FRAC_W)
`endif
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .load_i (load),
            .tick_i (tick),
            .div_i  (div[DLO +: DIV_W]),
            .phase_i(phase[DLO +: DIV_W]),
`ifdef CLKEN_FRAC_EN
            .frac_i (frac[FLO +: FRAC_W]),
`endif
            .ce_o   (ce[g])
        );
    end

    assign ready     = ready_q;
    assign lock_lost = lost_q;
    assign state     = state_q;

endmodule
